// File: rtl/graph_mem_arbiter_if.sv
// CPU-side request/acknowledge bus of the frame-buffer arbiter.
// The CPU drives the request; the arbiter returns a one-cycle ack and read data.
interface graph_mem_arbiter_if #(
  parameter int ADDR_W = 26,
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ack, rdata);
  modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/graph_mem_arbiter.sv
// Timed access arbiter sharing one async PSRAM between the CPU and the VGA scan-out.
// VGA words are prefetched into a first-word-fall-through FIFO from an auto-incrementing frame address.
//
// state   | meaning
// IDLE    | choose next access (VGA when FIFO below half, else CPU, else VGA while not full)
// VGA_RD  | frame-buffer read strobe for the prefetch FIFO
// CPU_RD  | CPU read strobe, data captured on the last cycle
// CPU_WR  | CPU write strobe, bus driven with write data
// RECOVER | strobes released for one cycle, write data still held, CPU ack issued
module graph_mem_arbiter #(
  parameter int ADDR_W        = 26,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 4,
  parameter int FIFO_DEPTH    = 8,
  parameter int FRAME_WORDS   = 38400
) (
  input  logic              i_clk,
  input  logic              i_rst,
  graph_mem_arbiter_if.slave cpu,
  input  logic              i_vga_start,
  input  logic [ADDR_W-1:0] i_vga_base,
  input  logic              i_vga_pop,
  output logic [DATA_W-1:0] o_vga_data,
  output logic              o_vga_valid,
  output logic              o_vga_underflow,
  output logic [ADDR_W-1:0] o_mem_adr,
  output logic [DATA_W-1:0] o_mem_dq_out,
  output logic              o_mem_dq_oe,
  input  logic [DATA_W-1:0] i_mem_dq_in,
  output logic              o_mem_ce_n,
  output logic              o_mem_oe_n,
  output logic              o_mem_we_n
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CYC_W = $clog2(ACCESS_CYCLES);
  localparam int REM_W = $clog2(FRAME_WORDS + 1);
  localparam logic [CNT_W-1:0] HALF     = CNT_W'(FIFO_DEPTH / 2);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [CYC_W-1:0] CYC_LOAD = CYC_W'(ACCESS_CYCLES - 1);
  localparam logic [REM_W-1:0] REM_LOAD = REM_W'(FRAME_WORDS);

  typedef enum logic [2:0] {IDLE, VGA_RD, CPU_RD, CPU_WR, RECOVER} state_t;

  state_t            r_state;
  logic [CYC_W-1:0]  r_cnt;
  logic              r_discard;
  logic [ADDR_W-1:0] r_fetch_addr;
  logic [REM_W-1:0]  r_remaining;
  logic              r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic [ADDR_W-1:0] r_mem_adr;
  logic [DATA_W-1:0] r_mem_dq_out;
  logic              r_mem_dq_oe;
  logic              r_mem_ce_n;
  logic              r_mem_oe_n;
  logic              r_mem_we_n;

  logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;
  logic [CNT_W-1:0]  r_count;
  logic              r_vga_valid;
  logic [DATA_W-1:0] r_vga_data;
  logic              r_underflow;

  logic              w_fetch_act;
  logic              w_go_vga;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_rd_nxt;
  logic [CNT_W-1:0]  w_count_nxt;

  assign w_fetch_act = (r_remaining != '0);
  // A frame restart in the same cycle never launches a fetch from the stale address.
  assign w_go_vga    = (r_state == IDLE) && w_fetch_act && !i_vga_start &&
                       ((r_count < HALF) || (!cpu.req && (r_count != FULL)));
  assign w_push      = (r_state == VGA_RD) && (r_cnt == '0) && !r_discard && !i_vga_start;
  assign w_pop       = i_vga_pop && (r_count != '0) && !i_vga_start;
  assign w_rd_nxt    = r_rd + PTR_W'(1);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_discard    <= 1'b0;
      r_fetch_addr <= '0;
      r_remaining  <= '0;
      r_ack        <= 1'b0;
      r_rdata      <= '0;
      r_mem_adr    <= '0;
      r_mem_dq_out <= '0;
      r_mem_dq_oe  <= 1'b0;
      r_mem_ce_n   <= 1'b1;
      r_mem_oe_n   <= 1'b1;
      r_mem_we_n   <= 1'b1;
    end else begin
      r_ack <= 1'b0;
      if (i_vga_start) begin
        r_fetch_addr <= i_vga_base;
        r_remaining  <= REM_LOAD;
      end else if (w_push) begin
        r_fetch_addr <= r_fetch_addr + ADDR_W'(1);
        r_remaining  <= r_remaining - REM_W'(1);
      end
      case (r_state)
        IDLE: begin
          if (w_go_vga) begin
            r_state    <= VGA_RD;
            r_cnt      <= CYC_LOAD;
            r_discard  <= 1'b0;
            r_mem_adr  <= r_fetch_addr;
            r_mem_ce_n <= 1'b0;
            r_mem_oe_n <= 1'b0;
          end else if (cpu.req) begin
            r_cnt      <= CYC_LOAD;
            r_mem_adr  <= cpu.addr;
            r_mem_ce_n <= 1'b0;
            if (cpu.we) begin
              r_state      <= CPU_WR;
              r_mem_we_n   <= 1'b0;
              r_mem_dq_oe  <= 1'b1;
              r_mem_dq_out <= cpu.wdata;
            end else begin
              r_state    <= CPU_RD;
              r_mem_oe_n <= 1'b0;
            end
          end
        end
        VGA_RD, CPU_RD, CPU_WR: begin
          // Restarted frame: let the strobe finish but drop its word.
          if ((r_state == VGA_RD) && i_vga_start) r_discard <= 1'b1;
          if (r_cnt == '0) begin
            r_state    <= RECOVER;
            r_mem_ce_n <= 1'b1;
            r_mem_oe_n <= 1'b1;
            r_mem_we_n <= 1'b1;
            if (r_state == CPU_RD) begin
              r_rdata <= i_mem_dq_in;
              r_ack   <= 1'b1;
            end
            if (r_state == CPU_WR) r_ack <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CYC_W'(1);
          end
        end
        RECOVER: begin
          r_state     <= IDLE;
          r_mem_dq_oe <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr] <= i_mem_dq_in;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_vga_valid <= 1'b0;
      r_vga_data  <= '0;
      r_underflow <= 1'b0;
    end else if (i_vga_start) begin
      r_wr        <= '0;
      r_rd        <= '0;
      r_count     <= '0;
      r_vga_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + PTR_W'(1);
      if (w_pop) r_rd <= w_rd_nxt;
      if (i_vga_pop && (r_count == '0)) r_underflow <= 1'b1;
      r_count     <= w_count_nxt;
      r_vga_valid <= (w_count_nxt != '0);
      // Registered head: next stored word, or the incoming word when the FIFO is about to hold only it.
      if (w_pop && (r_count > CNT_W'(1))) r_vga_data <= r_fifo[w_rd_nxt];
      else if (w_push && ((r_count == '0) || w_pop)) r_vga_data <= i_mem_dq_in;
    end
  end

  assign cpu.ack         = r_ack;
  assign cpu.rdata       = r_rdata;
  assign o_vga_data      = r_vga_data;
  assign o_vga_valid     = r_vga_valid;
  assign o_vga_underflow = r_underflow;
  assign o_mem_adr       = r_mem_adr;
  assign o_mem_dq_out    = r_mem_dq_out;
  assign o_mem_dq_oe     = r_mem_dq_oe;
  assign o_mem_ce_n      = r_mem_ce_n;
  assign o_mem_oe_n      = r_mem_oe_n;
  assign o_mem_we_n      = r_mem_we_n;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Directed bench for graph_mem_arbiter: CPU op table plus frame-fetch, arbitration,
// restart, underflow and mid-access reset sequences against a combinational RAM model.
module tb_graph_mem_arbiter;
  localparam int AW = 26;
  localparam int DW = 16;
  localparam int FW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  graph_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) cpu_if ();

  logic          vga_start = 1'b0;
  logic [AW-1:0] vga_base  = '0;
  logic          vga_pop   = 1'b0;
  logic [DW-1:0] vga_data;
  logic          vga_valid;
  logic          vga_underflow;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_dq_out;
  logic [DW-1:0] mem_dq_in;
  logic          mem_dq_oe;
  logic          mem_ce_n;
  logic          mem_oe_n;
  logic          mem_we_n;

  function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
    if (a == 26'h123) return 16'h5A5A;
    return a[15:0] ^ 16'hC3A5;
  endfunction

  assign mem_dq_in = ram_val(mem_adr);

  graph_mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4), .FIFO_DEPTH(8), .FRAME_WORDS(FW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .cpu(cpu_if),
    .i_vga_start(vga_start), .i_vga_base(vga_base), .i_vga_pop(vga_pop),
    .o_vga_data(vga_data), .o_vga_valid(vga_valid), .o_vga_underflow(vga_underflow),
    .o_mem_adr(mem_adr), .o_mem_dq_out(mem_dq_out), .o_mem_dq_oe(mem_dq_oe),
    .i_mem_dq_in(mem_dq_in), .o_mem_ce_n(mem_ce_n), .o_mem_oe_n(mem_oe_n),
    .o_mem_we_n(mem_we_n)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Every access start (chip enable falling) is logged with its address.
  logic [AW-1:0] acc_q[$];
  logic prev_ce = 1'b1;
  always @(negedge clk) begin
    if (!rst && !mem_ce_n && prev_ce) acc_q.push_back(mem_adr);
    prev_ce <= mem_ce_n;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cpu_op(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                        input logic [DW-1:0] exp_rdata, input int exp_lat);
    int lat = 0;
    int n_strb = 0;
    int n_wrong = 0;
    cpu_if.req = 1'b1; cpu_if.we = we; cpu_if.addr = addr; cpu_if.wdata = wdata;
    do begin
      @(negedge clk);
      lat++;
      if (!cpu_if.ack && !mem_ce_n && mem_adr == addr) begin
        if (we ? (!mem_we_n && mem_oe_n && mem_dq_oe && mem_dq_out == wdata)
               : (mem_we_n && !mem_oe_n && !mem_dq_oe)) n_strb++;
        else n_wrong++;
      end
    end while (!cpu_if.ack && lat < 300);
    check("cpu_ack_seen", cpu_if.ack, 1);
    if (exp_lat != 0) check("cpu_latency", lat, exp_lat);
    check("strobe_cycles", n_strb, 4);
    check("strobe_wrong", n_wrong, 0);
    check("recover_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("recover_dq_oe", mem_dq_oe, we);
    check("cpu_rdata", cpu_if.rdata, exp_rdata);
    cpu_if.req = 1'b0;
    @(negedge clk);
    check("ack_one_cycle", cpu_if.ack, 0);
    check("dq_oe_released", mem_dq_oe, 0);
    check("rdata_hold", cpu_if.rdata, exp_rdata);
  endtask

  task automatic fetch_check(input logic [AW-1:0] base, input int n, input int gap);
    int got = 0;
    int cyc = 0;
    logic [AW-1:0] a;
    while (got < n && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      vga_pop = 1'b0;
      if ((cyc % gap) == 0 && vga_valid) begin
        a = base + AW'(got);
        check("vga_data", vga_data, ram_val(a));
        vga_pop = 1'b1;
        got++;
      end
    end
    @(negedge clk);
    vga_pop = 1'b0;
    check("fetch_words", got, n);
  endtask

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[5];
  logic [AW-1:0] arb_exp[9];

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int acks;
    cpu_if.req = 1'b0; cpu_if.we = 1'b0; cpu_if.addr = '0; cpu_if.wdata = '0;
    vecs[0] = '{1'b1, 26'h0000123, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 26'h0000123, 16'h0000, 16'h5A5A};
    vecs[2] = '{1'b1, 26'h3FFFFFF, 16'h1234, 16'h5A5A};
    vecs[3] = '{1'b0, 26'h0000042, 16'h0000, 16'hC3E7};
    vecs[4] = '{1'b0, 26'h3FFFFFF, 16'h0000, 16'h3C5A};
    arb_exp = '{26'h2000, 26'h2001, 26'h2002, 26'h2003, 26'h555,
                26'h2004, 26'h2005, 26'h2006, 26'h2007};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ack", cpu_if.ack, 0);
    check("rst_rdata", cpu_if.rdata, 0);
    check("rst_underflow", vga_underflow, 0);
    check("rst_valid", vga_valid, 0);
    check("rst_vga_data", vga_data, 0);
    check("rst_adr", mem_adr, 0);
    check("rst_dq_out", mem_dq_out, 0);
    check("rst_dq_oe", mem_dq_oe, 0);
    check("rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);

    for (int i = 0; i < 5; i++)
      cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, 5);

    // Frame fetch with slow consumer
    acc_q.delete();
    vga_base = 26'h1000; vga_start = 1'b1;
    @(negedge clk);
    vga_start = 1'b0;
    fetch_check(26'h1000, FW, 6);
    repeat (20) @(negedge clk);
    check("frame_accesses", acc_q.size(), 16);
    for (int i = 0; i < acc_q.size() && i < 16; i++)
      check("frame_addr", acc_q[i], 32'h1000 + i);
    check("frame_valid_end", vga_valid, 0);
    check("frame_underflow", vga_underflow, 0);

    // Arbitration: CPU waits for exactly half the FIFO to fill
    acc_q.delete();
    vga_base = 26'h2000; vga_start = 1'b1;
    @(negedge clk);
    vga_start = 1'b0;
    cpu_op(1'b0, 26'h555, 16'h0000, 16'hC6F0, 0);
    repeat (40) @(negedge clk);
    check("arb_accesses", acc_q.size(), 9);
    for (int i = 0; i < acc_q.size() && i < 9; i++)
      check("arb_order", acc_q[i], arb_exp[i]);
    check("arb_fifo_valid", vga_valid, 1);
    fetch_check(26'h2000, FW, 1);
    repeat (10) @(negedge clk);
    check("arb_total_accesses", acc_q.size(), 17);

    // Restart during a VGA read, new base wrapping past the top of memory
    acc_q.delete();
    vga_base = 26'h3000; vga_start = 1'b1;
    @(negedge clk);
    vga_start = 1'b0;
    w = 0;
    while (acc_q.size() < 3 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("restart_reached", acc_q.size(), 3);
    check("restart_in_read", mem_oe_n, 0);
    check("restart_pre_valid", vga_valid, 1);
    vga_base = 26'h3FFFFFF; vga_start = 1'b1;
    @(negedge clk);
    vga_start = 1'b0;
    check("flush_valid", vga_valid, 0);
    fetch_check(26'h3FFFFFF, FW, 2);
    check("restart_size", acc_q.size(), 19);
    if (acc_q.size() >= 6) begin
      check("restart_discarded_adr", acc_q[2], 26'h3002);
      check("restart_new_base", acc_q[3], 26'h3FFFFFF);
      check("restart_wrap0", acc_q[4], 26'h0);
      check("restart_wrap1", acc_q[5], 26'h1);
    end
    repeat (20) @(negedge clk);
    check("wrap_drained", vga_valid, 0);
    check("wrap_last_data", vga_data, 16'hC3AB);

    // Pop on empty
    check("no_underflow_yet", vga_underflow, 0);
    vga_pop = 1'b1;
    @(negedge clk);
    vga_pop = 1'b0;
    check("underflow_set", vga_underflow, 1);
    check("underflow_data_held", vga_data, 16'hC3AB);
    check("underflow_valid", vga_valid, 0);
    repeat (5) @(negedge clk);
    check("underflow_sticky", vga_underflow, 1);
    vga_base = 26'h4000; vga_start = 1'b1;
    @(negedge clk);
    vga_start = 1'b0;
    check("underflow_cleared", vga_underflow, 0);

    // Reset in the middle of a CPU write
    cpu_if.req = 1'b1; cpu_if.we = 1'b1; cpu_if.addr = 26'h77; cpu_if.wdata = 16'hAAAA;
    w = 0;
    while ((mem_we_n || mem_adr != 26'h77) && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("wr_started", mem_we_n, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_strobes", {mem_ce_n, mem_oe_n, mem_we_n}, 3'b111);
    check("mid_rst_dq_oe", mem_dq_oe, 0);
    check("mid_rst_ack", cpu_if.ack, 0);
    check("mid_rst_valid", vga_valid, 0);
    rst = 1'b0;
    cpu_if.req = 1'b0;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (cpu_if.ack) acks++;
    end
    check("no_ack_after_reset", acks, 0);
    cpu_op(1'b1, 26'h88, 16'h5555, 16'h0000, 5);
    cpu_op(1'b0, 26'h123, 16'h0000, 16'h5A5A, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
